// File: rtl/stream_cipher_unit.sv
// Keystream cipher datapath: prefetches generator key slices into a small FIFO and
// XORs them onto a valid/ready word stream, passing sync markers through unkeyed.
module stream_cipher_unit #(
    parameter int                DATA_W          = 16,
    parameter int                KEY_W           = 32,
    parameter int                KEY_LSB         = 12,
    parameter logic [DATA_W-1:0] SYNC_WORD       = 16'hCAFE,
    parameter int                FIFO_DEPTH      = 4,
    parameter int                RESYNC_INTERVAL = 256,
    localparam int               CNT_W           = $clog2(RESYNC_INTERVAL),
    localparam int               LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_is_sync,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_is_sync,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_valid,
    output logic              key_req,
    output logic              sync_due,
    output logic [CNT_W-1:0]  words_processed,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  DEPTH_L  = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RESYNC_INTERVAL - 1);

    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              outstanding_q, outstanding_d;
    logic              key_req_q, key_req_d;
    logic              m_valid_q, m_valid_d;
    logic              m_is_sync_q, m_is_sync_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sync_due_q, sync_due_d;
    logic              bypass, accept, pop, push, still_waiting;

    // Handshake: a word moves when valid && ready on the same rising edge; s_ready
    // never depends on s_valid, and m_data/m_is_sync hold while m_valid && !m_ready.
    assign bypass        = mode ? (s_data == SYNC_WORD) : s_is_sync;
    assign s_ready       = (!m_valid_q || m_ready) && (bypass || (level_q != '0)) && !flush;
    assign accept        = s_valid && s_ready;
    assign pop           = accept && !bypass;
    assign push          = key_valid && outstanding_q && !flush && ((level_q != DEPTH_L) || pop);
    assign still_waiting = outstanding_q && !key_valid;

    // A key arriving this cycle frees the request slot, so the next request can
    // go out on the same edge and refill runs at one key per two cycles.
    always_comb begin
        level_d       = flush ? '0 : (level_q + LVL_W'(push) - LVL_W'(pop));
        key_req_d     = !flush && !still_waiting && (level_d < DEPTH_L);
        outstanding_d = !flush && (still_waiting || key_req_d);
    end

    always_comb begin
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_is_sync_d = m_is_sync_q;
        count_d     = count_q;
        sync_due_d  = 1'b0;
        if (flush) begin
            m_valid_d   = 1'b0;
            m_data_d    = '0;
            m_is_sync_d = 1'b0;
            count_d     = '0;
        end else begin
            if (accept) begin
                m_valid_d   = 1'b1;
                m_data_d    = bypass ? s_data : (s_data ^ fifo_q[rd_ptr_q]);
                m_is_sync_d = bypass;
            end else if (m_ready) begin
                m_valid_d = 1'b0;
            end
            if (pop) begin
                if (count_q == CNT_LAST) begin
                    count_d    = '0;
                    sync_due_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= key_in[KEY_LSB +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            outstanding_q <= 1'b0;
            key_req_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_is_sync_q   <= 1'b0;
            count_q       <= '0;
            sync_due_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= flush ? '0 : (wr_ptr_q + PTR_W'(push));
            rd_ptr_q      <= flush ? '0 : (rd_ptr_q + PTR_W'(pop));
            level_q       <= level_d;
            outstanding_q <= outstanding_d;
            key_req_q     <= key_req_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_is_sync_q   <= m_is_sync_d;
            count_q       <= count_d;
            sync_due_q    <= sync_due_d;
        end
    end

    assign m_data          = m_data_q;
    assign m_is_sync       = m_is_sync_q;
    assign m_valid         = m_valid_q;
    assign key_req         = key_req_q;
    assign sync_due        = sync_due_q;
    assign words_processed = count_q;
    assign fifo_level      = level_q;

endmodule

// File: tb/tb_stream_cipher_unit.sv
// Bench for stream_cipher_unit: directed vector table and corner sequences, then
// random traffic against a queue-based keystream model.
module tb_stream_cipher_unit;

    localparam int DW = 16;
    localparam int KW = 32;
    localparam int KL = 12;
    localparam int FD = 4;
    localparam int RI = 4;
    localparam int CW = $clog2(RI);
    localparam int LW = $clog2(FD) + 1;
    localparam logic [DW-1:0] SYNC = 16'hCAFE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_is_sync = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_is_sync;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [KW-1:0] key_in = '0;
    logic          key_valid = 1'b0;
    logic          key_req;
    logic          sync_due;
    logic [CW-1:0] words_processed;
    logic [LW-1:0] fifo_level;

    // clock / reset
    always #5 clk = ~clk;

    stream_cipher_unit #(
        .DATA_W(DW), .KEY_W(KW), .KEY_LSB(KL), .SYNC_WORD(SYNC),
        .FIFO_DEPTH(FD), .RESYNC_INTERVAL(RI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .flush(flush),
        .s_data(s_data), .s_is_sync(s_is_sync), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_is_sync(m_is_sync), .m_valid(m_valid), .m_ready(m_ready),
        .key_in(key_in), .key_valid(key_valid), .key_req(key_req),
        .sync_due(sync_due), .words_processed(words_processed), .fifo_level(fifo_level)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // reference model: keystream slices waiting to be used, plus expected outputs
    logic [DW-1:0] exp_q[$];
    bit            req_open = 1'b0;
    bit            req_exp  = 1'b0;
    bit            mv_exp   = 1'b0;
    logic [DW-1:0] md_exp   = '0;
    bit            ms_exp   = 1'b0;
    int            cnt_exp  = 0;
    bit            sd_exp   = 1'b0;

    // generator model
    bit            gen_en    = 1'b1;
    bit            gen_noise = 1'b0;
    bit            gen_pend  = 1'b0;
    int            gen_lat   = 1;
    int            gen_cnt   = 0;
    logic [KW-1:0] key_word  = 32'h0ABCD000;

    typedef struct {
        bit            md;
        logic [DW-1:0] din;
        bit            iss;
        logic [DW-1:0] dout;
        bit            osync;
        int            cnt;
        bit            sd;
        int            lvl;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step(input bit sv, input bit md, input logic [DW-1:0] d, input bit iss,
                        input bit mr, input bit fl);
        bit            byp, rdy, acc, kv;
        logic [DW-1:0] head;
        check("m_valid", m_valid, mv_exp);
        if (mv_exp) begin
            check("m_data", m_data, md_exp);
            check("m_is_sync", m_is_sync, ms_exp);
        end
        check("fifo_level", fifo_level, exp_q.size());
        check("words_processed", words_processed, cnt_exp);
        check("sync_due", sync_due, sd_exp);
        check("key_req", key_req, req_exp);

        if (key_req) begin
            gen_pend = 1'b1;
            gen_cnt  = gen_lat;
        end
        kv = 1'b0;
        if (gen_pend && gen_en) begin
            if (gen_cnt == 0) begin
                kv       = 1'b1;
                gen_pend = 1'b0;
            end else begin
                gen_cnt--;
            end
        end else if (!gen_pend && gen_noise && ($urandom_range(0, 7) == 0)) begin
            kv = 1'b1;
        end

        s_valid = sv; mode = md; s_data = d; s_is_sync = iss;
        m_ready = mr; flush = fl; key_valid = kv; key_in = key_word;
        #1;
        byp = md ? (d == SYNC) : iss;
        rdy = (!mv_exp || mr) && (byp || (exp_q.size() > 0)) && !fl;
        check("s_ready", s_ready, rdy);
        acc = sv && rdy;
        @(posedge clk);

        sd_exp = 1'b0;
        if (fl) begin
            exp_q.delete();
            req_open = 1'b0;
            req_exp  = 1'b0;
            mv_exp   = 1'b0;
            cnt_exp  = 0;
        end else begin
            if (acc) begin
                mv_exp = 1'b1;
                ms_exp = byp;
                if (byp) begin
                    md_exp = d;
                end else begin
                    head   = exp_q.pop_front();
                    md_exp = d ^ head;
                    cnt_exp++;
                    if (cnt_exp == RI) begin
                        cnt_exp = 0;
                        sd_exp  = 1'b1;
                    end
                end
            end else if (mr) begin
                mv_exp = 1'b0;
            end
            if (kv && req_open) begin
                if (exp_q.size() < FD) exp_q.push_back(key_word[KL +: DW]);
                req_open = 1'b0;
            end
            // a new request goes out whenever none is open and the queue has room
            req_exp = !req_open && (exp_q.size() < FD);
            if (req_exp) req_open = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 1'b0, 16'hB9F9, 1'b0, 1, 1'b0, 3};
        vecs[1] = '{1'b0, 16'hB9F9, 1'b0, 16'h1234, 1'b0, 2, 1'b0, 3};
        vecs[2] = '{1'b1, 16'hCAFE, 1'b0, 16'hCAFE, 1'b1, 2, 1'b0, 4};
        vecs[3] = '{1'b0, 16'h5555, 1'b1, 16'h5555, 1'b1, 2, 1'b0, 4};
        vecs[4] = '{1'b0, 16'hCAFE, 1'b0, 16'h6133, 1'b0, 3, 1'b0, 3};
        vecs[5] = '{1'b1, 16'h0000, 1'b0, 16'hABCD, 1'b0, 0, 1'b1, 3};
        vecs[6] = '{1'b1, 16'h0F0F, 1'b1, 16'hA4C2, 1'b0, 1, 1'b0, 3};

        repeat (3) @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_is_sync", m_is_sync, 0);
        check("rst_m_data", m_data, 0);
        check("rst_key_req", key_req, 0);
        check("rst_sync_due", sync_due, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_words", words_processed, 0);
        rst_n = 1'b1;

        // prefetch with a one-cycle generator
        idle(12);
        check("prefetch_level", fifo_level, 4);
        idle(1);
        check("prefetch_req_quiet", key_req, 0);

        // vector table
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vecs[i].md, vecs[i].din, vecs[i].iss, 1'b1, 1'b0);
            check("vec_m_valid", m_valid, 1);
            check("vec_m_data", m_data, vecs[i].dout);
            check("vec_m_is_sync", m_is_sync, vecs[i].osync);
            check("vec_words", words_processed, vecs[i].cnt);
            check("vec_sync_due", sync_due, vecs[i].sd);
            check("vec_level", fifo_level, vecs[i].lvl);
            idle(6);
        end

        // backpressure: output held, nothing further accepted or popped
        step(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
            check("bp_hold_data", m_data, 16'hBADC);
            check("bp_hold_valid", m_valid, 1);
        end
        check("bp_level", fifo_level, 4);
        check("bp_words", words_processed, 2);
        idle(2);

        // starve the generator: keyed words stall, a marker still passes
        gen_en = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0);
        check("empty_level", fifo_level, 0);
        check("empty_words", words_processed, 2);
        step(1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0);
        check("empty_stall", m_valid, 0);
        step(1'b1, 1'b1, SYNC, 1'b0, 1'b1, 1'b0);
        check("empty_bypass_valid", m_valid, 1);
        check("empty_bypass_data", m_data, 16'hCAFE);
        check("empty_bypass_sync", m_is_sync, 1);

        // flush with a request open and an output pending
        step(1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b1);
        check("flush_m_valid", m_valid, 0);
        check("flush_level", fifo_level, 0);
        check("flush_words", words_processed, 0);
        check("flush_key_req", key_req, 0);
        check("flush_sync_due", sync_due, 0);
        gen_en  = 1'b1;
        gen_cnt = 0;
        idle(1);
        check("late_key_level", fifo_level, 0);
        check("late_key_req", key_req, 1);
        check("late_key_m_valid", m_valid, 0);
        idle(10);
        check("refill_level", fifo_level, 4);

        // random traffic
        gen_noise = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] d;
            gen_lat  = $urandom_range(0, 3);
            gen_en   = ($urandom_range(0, 9) != 0);
            key_word = $urandom;
            d        = ($urandom_range(0, 3) == 0) ? SYNC : DW'($urandom);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), d,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
